// File: rtl/pll_ctrl.sv
// pll_ctrl: PLL reset/lock sequencer with optional dynamic phase stepping.
// Optional feature macro: PLL_CTRL_PHASE_EN compiles in the phase-step
// request path and the STEP_*/LOAD_* states. Without it the phase outputs
// are held at their idle values and the request inputs are ignored.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   pll_locked_i          raw PLL LOCK (asynchronous to clk)
//   pll_rst_o             PLL RST
//   sys_reset_o, ready_o  downstream reset and its inverse
//   phase_req_*           phase step request handshake (valid/ready, sel, dir, steps)
//   pll_phase*_o          PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG to the PLL
//   lock_loss_count_o     saturating count of lock losses after release
module pll_ctrl #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STEP_PULSE_CYCLES  = 4,
  parameter int unsigned STEP_GAP_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked_i,
  output logic       pll_rst_o,
  output logic       sys_reset_o,
  output logic       ready_o,
  input  logic       phase_req_valid_i,
  output logic       phase_req_ready_o,
  input  logic [1:0] phase_req_sel_i,
  input  logic       phase_req_dir_i,
  input  logic [7:0] phase_req_steps_i,
  output logic [1:0] pll_phasesel_o,
  output logic       pll_phasedir_o,
  output logic       pll_phasestep_o,
  output logic       pll_phaseloadreg_o,
  output logic [7:0] lock_loss_count_o
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CD  = (STEP_PULSE_CYCLES > STEP_GAP_CYCLES) ?
                                    STEP_PULSE_CYCLES : STEP_GAP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_CTRL_PHASE_EN
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(STEP_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STEP_GAP_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3
`ifdef PLL_CTRL_PHASE_EN
    ,
    STEP_LOW  = 3'd4,
    STEP_HIGH = 3'd5,
    LOAD_LOW  = 3'd6,
    LOAD_HIGH = 3'd7
`endif
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [7:0]       loss_cnt;
  logic [7:0]       loss_cnt_d;
  logic             sync_meta;
  logic             lk;

  logic             pll_rst_d;
  logic             sys_reset_d;
  logic             phase_ready_d;
  logic             step_d;
  logic             load_d;

`ifdef PLL_CTRL_PHASE_EN
  logic [1:0]       sel_q;
  logic [1:0]       sel_d;
  logic             dir_q;
  logic             dir_d;
  logic [7:0]       steps_left;
  logic [7:0]       steps_left_d;
`else
  logic             unused_phase;
  assign unused_phase = ^{phase_req_valid_i, phase_req_sel_i,
                          phase_req_dir_i, phase_req_steps_i};
`endif

  // Two-flop synchronizer for the asynchronous LOCK input
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      lk        <= 1'b0;
    end else begin
      sync_meta <= pll_locked_i;
      lk        <= sync_meta;
    end
  end

  // State register; outputs are registered from the next-state decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= PLL_RST;
      cnt                <= '0;
      loss_cnt           <= '0;
      pll_rst_o          <= 1'b1;
      sys_reset_o        <= 1'b1;
      ready_o            <= 1'b0;
      phase_req_ready_o  <= 1'b0;
      pll_phasestep_o    <= 1'b1;
      pll_phaseloadreg_o <= 1'b1;
`ifdef PLL_CTRL_PHASE_EN
      sel_q              <= 2'd0;
      dir_q              <= 1'b1;
      steps_left         <= 8'd0;
`endif
    end else begin
      state              <= next_state;
      cnt                <= cnt_d;
      loss_cnt           <= loss_cnt_d;
      pll_rst_o          <= pll_rst_d;
      sys_reset_o        <= sys_reset_d;
      ready_o            <= ~sys_reset_d;
      phase_req_ready_o  <= phase_ready_d;
      pll_phasestep_o    <= step_d;
      pll_phaseloadreg_o <= load_d;
`ifdef PLL_CTRL_PHASE_EN
      sel_q              <= sel_d;
      dir_q              <= dir_d;
      steps_left         <= steps_left_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    loss_cnt_d = loss_cnt;
`ifdef PLL_CTRL_PHASE_EN
    sel_d        = sel_q;
    dir_d        = dir_q;
    steps_left_d = steps_left;
`endif
    unique case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          next_state = WAIT_LOCK;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        // The cycle that sees lock is the first of the stable run
        if (lk) begin
          next_state = STABLE;
          cnt_d      = CNT_W'(1);
        end
      end
      STABLE: begin
        if (!lk) begin
          next_state = WAIT_LOCK;
          cnt_d      = '0;
        end else if (cnt >= STABLE_LAST) begin
          next_state = RUN;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RUN: begin
`ifdef PLL_CTRL_PHASE_EN
        if (lk && phase_req_valid_i && phase_req_ready_o) begin
          sel_d = phase_req_sel_i;
          dir_d = phase_req_dir_i;
          if (phase_req_steps_i != 8'd0) begin
            next_state   = STEP_LOW;
            cnt_d        = '0;
            steps_left_d = phase_req_steps_i;
          end
        end
`endif
      end
`ifdef PLL_CTRL_PHASE_EN
      STEP_LOW: begin
        if (cnt == PULSE_LAST) begin
          next_state = STEP_HIGH;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      STEP_HIGH: begin
        if (cnt == GAP_LAST) begin
          cnt_d = '0;
          if (steps_left == 8'd1) begin
            next_state = LOAD_LOW;
          end else begin
            next_state   = STEP_LOW;
            steps_left_d = steps_left - 8'd1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      LOAD_LOW: begin
        if (cnt == PULSE_LAST) begin
          next_state = LOAD_HIGH;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      LOAD_HIGH: begin
        if (cnt == GAP_LAST) begin
          next_state = RUN;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`endif
      default: begin
        next_state = PLL_RST;
        cnt_d      = '0;
      end
    endcase

    // Lock loss after release overrides everything and abandons any request
    if (!(state inside {PLL_RST, WAIT_LOCK, STABLE}) && !lk) begin
      next_state = PLL_RST;
      cnt_d      = '0;
      if (loss_cnt != 8'hFF) begin
        loss_cnt_d = loss_cnt + 8'd1;
      end
    end
  end

  // Output decode from next state (registered in the state register block)
  always_comb begin
    pll_rst_d     = (next_state == PLL_RST);
    sys_reset_d   = next_state inside {PLL_RST, WAIT_LOCK, STABLE};
    phase_ready_d = 1'b0;
    step_d        = 1'b1;
    load_d        = 1'b1;
`ifdef PLL_CTRL_PHASE_EN
    // sync_meta is the value lk takes on the same edge
    phase_ready_d = (next_state == RUN) && sync_meta;
    step_d        = (next_state != STEP_LOW);
    load_d        = (next_state != LOAD_LOW);
`endif
  end

`ifdef PLL_CTRL_PHASE_EN
  assign pll_phasesel_o = sel_q;
  assign pll_phasedir_o = dir_q;
`else
  assign pll_phasesel_o = 2'd0;
  assign pll_phasedir_o = 1'b1;
`endif

  assign lock_loss_count_o = loss_cnt;

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: directed self-checking bench for pll_ctrl with
// PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=16, STEP_PULSE_CYCLES=2, STEP_GAP_CYCLES=2.
// Phase-step scenarios run when PLL_CTRL_PHASE_EN is defined; otherwise the
// constant-output scenario runs. Cycle index i means "sampled 1 time unit
// after the i-th rising edge, counting the reset edge as 0".
module tb_pll_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lock = 1'b0;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       valid = 1'b0;
  logic       req_ready;
  logic [1:0] sel = 2'd0;
  logic       dir = 1'b0;
  logic [7:0] steps = 8'd0;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic [7:0] loss_count;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef PLL_CTRL_PHASE_EN
  localparam bit PHASE = 1'b1;
`else
  localparam bit PHASE = 1'b0;
`endif

  pll_ctrl #(
    .PLL_RST_CYCLES    (4),
    .LOCK_STABLE_CYCLES(16),
    .STEP_PULSE_CYCLES (2),
    .STEP_GAP_CYCLES   (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pll_locked_i      (lock),
    .pll_rst_o         (pll_rst),
    .sys_reset_o       (sys_reset),
    .ready_o           (ready),
    .phase_req_valid_i (valid),
    .phase_req_ready_o (req_ready),
    .phase_req_sel_i   (sel),
    .phase_req_dir_i   (dir),
    .phase_req_steps_i (steps),
    .pll_phasesel_o    (phasesel),
    .pll_phasedir_o    (phasedir),
    .pll_phasestep_o   (phasestep),
    .pll_phaseloadreg_o(phaseloadreg),
    .lock_loss_count_o (loss_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Runs from reset edge (index 0) for n cycles; reports pll_rst width,
  // first index with ready high, and sys_reset at index probe.
  task automatic run_from_reset(input int n, input int lo_at, input int probe,
                                output int rst_hi, output int first_rdy, output logic sys_probe);
    rst_hi    = 0;
    first_rdy = -1;
    sys_probe = 1'bx;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      if (pll_rst) rst_hi++;
      if (ready && first_rdy < 0) first_rdy = i;
      if (i == probe) sys_probe = sys_reset;
      if (lo_at >= 0 && i == lo_at) lock = 1'b0;
      if (lo_at >= 0 && i == lo_at + 1) lock = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         rst_hi;
    int         first_rdy;
    logic       sys_probe;
    bit         ok;
    logic [15:0] step_v;
    logic [15:0] load_v;
    bit         flag_a;
    bit         flag_b;
    bit         flag_c;

    // Reset values
    lock = 1'b1;
    do_reset();
    check_eq("rst_pll_rst", pll_rst, 1);
    check_eq("rst_sys_reset", sys_reset, 1);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_phasestep", phasestep, 1);
    check_eq("rst_loadreg", phaseloadreg, 1);
    check_eq("rst_phasedir", phasedir, 1);
    check_eq("rst_phasesel", phasesel, 0);
    check_eq("rst_loss_count", loss_count, 0);

    // Power-up: PLL_RST 4 + WAIT_LOCK 1 + 15 more stable samples -> release at index 20
    run_from_reset(40, -1, 19, rst_hi, first_rdy, sys_probe);
    check_eq("pwr_rst_width", rst_hi, 4);
    check_eq("pwr_release_idx", first_rdy, 20);
    check_eq("pwr_sys_reset_idx19", sys_probe, 1);
    check_eq("pwr_sys_reset_end", sys_reset, 0);
    check_eq("pwr_req_ready", req_ready, PHASE);
    check_eq("pwr_loss_count", loss_count, 0);

    // Glitch: raw lock low at edge 13 -> lk low at edge 15 (stable count 10);
    // restart at edge 16 -> release at index 31
    do_reset();
    run_from_reset(60, 12, 30, rst_hi, first_rdy, sys_probe);
    check_eq("glitch_release_idx", first_rdy, 31);
    check_eq("glitch_sys_reset_idx30", sys_probe, 1);
    check_eq("glitch_loss_count", loss_count, 0);

`ifdef PLL_CTRL_PHASE_EN
    // steps=3: transfer edge is k=0; pattern over k=0..15, RUN at k=16
    sel = 2'd2; dir = 1'b0; steps = 8'd3; valid = 1'b1;
    tick();
    valid = 1'b0;
    step_v = '0; load_v = '0; flag_a = 1'b1; flag_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      step_v[k] = phasestep;
      load_v[k] = phaseloadreg;
      if (phasesel != 2'd2 || phasedir != 1'b0) flag_a = 1'b0;
      if (req_ready) flag_b = 1'b1;
    end
    tick();
    check_eq("step3_phasestep", step_v, 32'h0000FCCC);
    check_eq("step3_loadreg", load_v, 32'h0000CFFF);
    check_eq("step3_sel_dir_held", flag_a, 1);
    check_eq("step3_busy_ready", flag_b, 0);
    check_eq("step3_ready_back", req_ready, 1);
    check_eq("step3_sys_reset", sys_reset, 0);

    // steps=0: no pulse, still accepting
    sel = 2'd1; dir = 1'b1; steps = 8'd0; valid = 1'b1;
    tick();
    valid = 1'b0;
    check_eq("step0_ready", req_ready, 1);
    check_eq("step0_phasestep", phasestep, 1);
    check_eq("step0_sel", phasesel, 1);
    tick();
    check_eq("step0_phasestep_next", phasestep, 1);

    // Lock loss in the second STEP_LOW (k=4,5): raw low after k=2 -> PLL_RST at k=5
    sel = 2'd3; dir = 1'b1; steps = 8'd4; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    lock = 1'b0;
    tick();
    tick();
    check_eq("loss_second_low", phasestep, 0);
    tick();
    check_eq("loss_phasestep", phasestep, 1);
    check_eq("loss_sys_reset", sys_reset, 1);
    check_eq("loss_req_ready", req_ready, 0);
    check_eq("loss_count_1", loss_count, 1);
    rst_hi = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pll_rst) rst_hi++;
    end
    check_eq("loss_rst_width", rst_hi, 4);
    check_eq("loss_count_hold", loss_count, 1);

    // Reset mid-step
    lock = 1'b1;
    wait_ready(64, ok);
    check_eq("midrst_wait_ready", ok, 1);
    sel = 2'd2; dir = 1'b0; steps = 8'd5; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_pll_rst", pll_rst, 1);
    check_eq("midrst_sys_reset", sys_reset, 1);
    check_eq("midrst_phasestep", phasestep, 1);
    check_eq("midrst_phasedir", phasedir, 1);
    check_eq("midrst_phasesel", phasesel, 0);
    check_eq("midrst_loss_count", loss_count, 0);
`else
    // Feature compiled out: request ignored, outputs constant
    sel = 2'd3; dir = 1'b0; steps = 8'd7; valid = 1'b1;
    flag_a = 1'b0; flag_b = 1'b0; flag_c = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (req_ready) flag_a = 1'b1;
      if (!phasestep || !phaseloadreg) flag_b = 1'b1;
      if (phasesel != 2'd0 || phasedir != 1'b1) flag_c = 1'b1;
    end
    valid = 1'b0;
    check_eq("nophase_req_ready", flag_a, 0);
    check_eq("nophase_pulses", flag_b, 0);
    check_eq("nophase_sel_dir", flag_c, 0);
    check_eq("nophase_ready", ready, 1);
`endif

    // Lock losses from RUN, saturating at 255
    lock = 1'b1;
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      wait_ready(64, ok);
      if (!ok) begin
        check_eq("sat_wait_ready", ok, 1);
        break;
      end
      lock = 1'b0;
      tick();
      tick();
      tick();
      if (n == 1) begin
        check_eq("sat_first_sys_reset", sys_reset, 1);
        check_eq("sat_first_count", loss_count, 1);
      end
      if (n == 254) check_eq("sat_count_254", loss_count, 254);
      lock = 1'b1;
    end
    check_eq("sat_count_300", loss_count, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
